// File: rtl/burst_read_arbiter_pkg.sv
// Shared definitions for the burst read arbiter and the burst detector.
// Holds the default widths and depth, the {burst_len, addr} request word
// layout (burst_len in the upper bits), the arbiter FSM encoding and the
// 2-way round-robin pick helper.
package burst_read_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF      = 64;
  localparam int unsigned BURST_LEN_WIDTH_DEF = 8;
  localparam int unsigned MAX_OUTSTANDING_DEF = 16;

  // Request word at default widths: burst_len above addr.
  typedef struct packed {
    logic [BURST_LEN_WIDTH_DEF-1:0] burst_len;
    logic [ADDR_WIDTH_DEF-1:0]      addr;
  } req_word_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // Round-robin pick: with both pending, the one that did not win last.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    logic pick;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else if (req1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/burst_arb_rr.sv
// 2-way round-robin arbiter with its own last_grant register.
// Ports:
//   clk, rst_n   clock, async active-low reset (last_grant resets to 1)
//   req0, req1   requesters pending
//   take         the presented grant is consumed this cycle
//   grant_valid  at least one requester pending
//   grant_idx    index of the requester that would win now
module burst_arb_rr
  import burst_read_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic grant_valid,
  output logic grant_idx
);

  logic last_grant_r;

  // Winner selection from pending requests and last winner.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = rr_pick(req0, req1, last_grant_r);
  end

  // Remember the last winner; reset value 1 lets requester 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (take) begin
      last_grant_r <= grant_idx;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/burst_read_arbiter.sv
// Arbitrates two FWFT request queues of {burst_len, addr} words onto one
// AXI AR channel, logs the grant order into an id FIFO and tracks the
// number of in-flight bursts from observed R-channel last beats.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   reqX_dout/empty_n/read      FWFT request queues (X = 0, 1)
//   m_axi_ar*                   AR channel master side
//   m_axi_rvalid/rready/rlast   observed R handshake (completion detect)
//   id_din/id_full_n/id_write   grant-order FIFO write side
//   outstanding                 in-flight burst count
//   err_underflow               sticky: completion seen with nothing in flight
module burst_read_arbiter
  import burst_read_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth      = ADDR_WIDTH_DEF,
  parameter int unsigned BurstLenWidth  = BURST_LEN_WIDTH_DEF,
  parameter int unsigned MaxOutstanding = MAX_OUTSTANDING_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [BurstLenWidth+AddrWidth-1:0] req0_dout,
  input  logic                               req0_empty_n,
  output logic                               req0_read,
  input  logic [BurstLenWidth+AddrWidth-1:0] req1_dout,
  input  logic                               req1_empty_n,
  output logic                               req1_read,
  output logic [AddrWidth-1:0]               m_axi_araddr,
  output logic [BurstLenWidth-1:0]           m_axi_arlen,
  output logic                               m_axi_arvalid,
  input  logic                               m_axi_arready,
  input  logic                               m_axi_rvalid,
  input  logic                               m_axi_rready,
  input  logic                               m_axi_rlast,
  output logic                               id_din,
  input  logic                               id_full_n,
  output logic                               id_write,
  output logic [$clog2(MaxOutstanding):0]    outstanding,
  output logic                               err_underflow
);

  localparam int unsigned CntWidth  = $clog2(MaxOutstanding) + 1;
  localparam int unsigned WordWidth = BurstLenWidth + AddrWidth;

  arb_state_e            state_r;
  arb_state_e            next_state_s;
  logic                  grant_s;
  logic                  grant_valid_s;
  logic                  grant_idx_s;
  logic                  below_limit_s;
  logic                  completion_s;
  logic [WordWidth-1:0]  sel_word_s;
  logic [AddrWidth-1:0]  araddr_r;
  logic [BurstLenWidth-1:0] arlen_r;
  logic [CntWidth-1:0]   outstanding_r;
  logic [CntWidth-1:0]   cnt_next_s;
  logic                  err_underflow_r;
  logic                  err_next_s;

  burst_arb_rr u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0_empty_n),
    .req1       (req1_empty_n),
    .take       (grant_s),
    .grant_valid(grant_valid_s),
    .grant_idx  (grant_idx_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state: one grant, then hold AR until accepted.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (m_axi_arready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs. Grant depends only on state, request and id FIFO status,
  // never on arready; rst_n gating keeps the strobes low while in reset.
  always_comb begin
    below_limit_s = (outstanding_r < CntWidth'(MaxOutstanding));
    if (rst_n && (state_r == ST_IDLE) && grant_valid_s && below_limit_s && id_full_n) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    req0_read     = grant_s & ~grant_idx_s;
    req1_read     = grant_s & grant_idx_s;
    id_write      = grant_s;
    id_din        = grant_idx_s;
    m_axi_arvalid = (state_r == ST_ISSUE);
  end

  // Request word of the current winner.
  always_comb begin
    if (grant_idx_s) begin
      sel_word_s = req1_dout;
    end else begin
      sel_word_s = req0_dout;
    end
  end

  // AR payload registers, loaded on grant and held through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_r <= {AddrWidth{1'b0}};
      arlen_r  <= {BurstLenWidth{1'b0}};
    end else if (grant_s) begin
      araddr_r <= sel_word_s[AddrWidth-1:0];
      arlen_r  <= sel_word_s[AddrWidth +: BurstLenWidth];
    end else begin
      araddr_r <= araddr_r;
      arlen_r  <= arlen_r;
    end
  end

  // In-flight count: a grant and a completion in the same cycle cancel;
  // a completion at zero saturates and flags underflow.
  always_comb begin
    completion_s = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    cnt_next_s   = outstanding_r;
    if (completion_s && (outstanding_r == {CntWidth{1'b0}})) begin
      err_next_s = 1'b1;
    end else begin
      err_next_s = err_underflow_r;
    end
    if (grant_s && !completion_s) begin
      cnt_next_s = outstanding_r + {{(CntWidth-1){1'b0}}, 1'b1};
    end else if (!grant_s && completion_s && (outstanding_r != {CntWidth{1'b0}})) begin
      cnt_next_s = outstanding_r - {{(CntWidth-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = outstanding_r;
    end
  end

  // Counter and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r   <= {CntWidth{1'b0}};
      err_underflow_r <= 1'b0;
    end else begin
      outstanding_r   <= cnt_next_s;
      err_underflow_r <= err_next_s;
    end
  end

  assign m_axi_araddr  = araddr_r;
  assign m_axi_arlen   = arlen_r;
  assign outstanding   = outstanding_r;
  assign err_underflow = err_underflow_r;

endmodule

// File: doc/burst_read_arbiter.md
BURST_READ_ARBITER -- requirements
Module: burst_read_arbiter

Interface
REQ-001 Parameter AddrWidth, default 64, meaning byte-address width of requests and AR channel.
REQ-002 Parameter BurstLenWidth, default 8, meaning AXI length field width (beats minus one).
REQ-003 Parameter MaxOutstanding, default 16, meaning maximum issued-but-incomplete bursts (power of two, at least 2).
REQ-004 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous assert, active-low reset.
REQ-007 req0_dout  input  BurstLenWidth+AddrWidth  first-word-fall-through word {burst_len, addr} from requester 0.
REQ-008 req0_empty_n  input  1  req0_dout valid.
REQ-009 req0_read  output  1  consume req0_dout this cycle.
REQ-010 req1_dout, req1_empty_n, req1_read  same widths and directions as req0, for requester 1.
REQ-011 m_axi_araddr  output  AddrWidth  issued burst address.
REQ-012 m_axi_arlen  output  BurstLenWidth  issued burst length.
REQ-013 m_axi_arvalid  output  1; m_axi_arready  input  1  AR handshake.
REQ-014 m_axi_rvalid, m_axi_rready, m_axi_rlast  input  1 each  observed R-channel handshake, not driven.
REQ-015 id_din  output  1  requester index of the granted burst.
REQ-016 id_full_n  input  1; id_write  output  1  grant-order FIFO handshake.
REQ-017 outstanding  output  $clog2(MaxOutstanding)+1  current in-flight burst count.
REQ-018 err_underflow  output  1  sticky flag, rlast seen with zero outstanding.

Function
REQ-019 FSM states: IDLE and ISSUE.
REQ-020 In IDLE, grant SHALL occur when at least one empty_n is high, outstanding < MaxOutstanding and id_full_n is high; otherwise no read and no id_write.
REQ-021 Arbitration is round-robin: with both requests pending, grant the requester other than last_grant; with one pending, grant it.
REQ-022 The grant cycle SHALL:
- pulse the winner's reqX_read and id_write for exactly one cycle;
- drive id_din to the winner index;
- latch burst_len and addr into the AR registers;
- increment outstanding;
- update last_grant;
- enter ISSUE.
REQ-023 In ISSUE, m_axi_arvalid SHALL be 1, with araddr and arlen held stable until arready.
REQ-024 On arvalid and arready, return to IDLE next cycle; minimum cadence is one burst per two cycles, and there is no grant in ISSUE.
REQ-025 m_axi_araddr equals the latched addr unmodified; m_axi_arlen equals the latched burst_len unmodified (no 4 KiB splitting).
REQ-026 A completion is rvalid, rready and rlast in the same cycle; it decrements outstanding.
REQ-027 If a grant and a completion occur in the same cycle, outstanding SHALL be unchanged.
REQ-028 On a completion with outstanding equal to 0, outstanding stays 0 and err_underflow sets, holding until reset.
REQ-029 outstanding never exceeds MaxOutstanding, because grant is gated per REQ-020.
REQ-030 reqX_read and id_write are Moore/registered-state decoded with no combinational path from m_axi_arready.

Reset
REQ-031 While rst_n is low, the block SHALL hold:
- state IDLE;
- arvalid 0, araddr 0, arlen 0;
- outstanding 0;
- err_underflow 0;
- last_grant 1, so requester 0 wins first.
REQ-032 Reset during ISSUE SHALL drop arvalid immediately (asynchronous) and discard the pending burst; its id entry is the id FIFO owner's concern.
REQ-033 req0_read, req1_read and id_write are 0 during reset.

Structure
REQ-034 A shared package holds AddrWidth, BurstLenWidth, MaxOutstanding defaults and the {burst_len, addr} request word layout, shared with the burst detector.
REQ-035 A sub-module burst_arb_rr (2-way round-robin, last_grant register) is instantiated once.
REQ-036 The outstanding counter and FSM stay in the top module.

Verification
REQ-037 Reset release, req0 holds {len=3, addr=0x1000}, arready=1 → read0 at cycle 1, AR {0x1000, 3} valid cycle 2, id_din=0, outstanding=1.
REQ-038 Both requesters pending continuously, arready=1, no R completions, MaxOutstanding=16 → grants alternate 0,1,0,1; the 17th request is not granted and outstanding holds at 16.
REQ-039 arready held low 5 cycles in ISSUE → arvalid, araddr and arlen stable all 5 cycles; no further reads; single AR accepted.
REQ-040 Grant and rlast completion in the same cycle with outstanding=4 → outstanding stays 4.
REQ-041 rlast completion with outstanding=0 → outstanding 0, err_underflow=1 and sticky.
REQ-042 id_full_n=0 with requests pending → no reads or grants; on deassert, grant resumes within 1 cycle; rst_n pulsed mid-ISSUE → arvalid 0 asynchronously.
